// File: rtl/pdm_deserializer.sv
// rtl/pdm_deserializer.sv - PDM microphone front end: bit clock generation and word capture
//
// Generates the microphone bit clock from the system clock and samples one
// (left) or two (left/right interleaved) PDM channels from dataIn. Bits are
// assembled MSB-first into WORD_LENGTH-bit words, and the word pair is offered
// on a valid/ready interface.
//
// Ports:
//   clock      in   system clock, rising-edge
//   resetN     in   asynchronous active-low reset
//   enable     in   run capture; low stops micClock and drops any partial word
//   dataIn     in   PDM data line
//   micClock   out  microphone bit clock (flop output)
//   LRSEL      out  channel select, tied to left (0)
//   leftData   out  last completed left word
//   rightData  out  last completed right word (0 in mono builds)
//   valid      out  leftData/rightData hold an unconsumed word
//   ready      in   consumer accepts the word
//   overrun    out  one-cycle pulse when an unconsumed word was overwritten
module pdm_deserializer #(
  parameter int WORD_LENGTH = 16,
  parameter int CLK_DIV     = 100,
  parameter int STEREO      = 0
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   enable,
  input  logic                   dataIn,
  output logic                   micClock,
  output logic                   LRSEL,
  output logic [WORD_LENGTH-1:0] leftData,
  output logic [WORD_LENGTH-1:0] rightData,
  output logic                   valid,
  input  logic                   ready,
  output logic                   overrun
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(WORD_LENGTH);

  localparam logic [DW-1:0] DIV_HALF      = DW'(CLK_DIV / 2);
  localparam logic [DW-1:0] DIV_HALF_LAST = DW'(CLK_DIV / 2 - 1);
  localparam logic [DW-1:0] DIV_LAST      = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST      = BW'(WORD_LENGTH - 1);

  logic [DW-1:0]          divCount;
  logic [DW-1:0]          divNext;
  logic [BW-1:0]          bitCount;
  logic                   running;
  logic [WORD_LENGTH-1:0] leftShift;
  // The right word's last bit is taken straight from dataIn on the completion
  // edge, so only WORD_LENGTH-1 bits of history are kept.
  logic [WORD_LENGTH-2:0] rightShift;
  logic [WORD_LENGTH-1:0] leftNext;
  logic [WORD_LENGTH-1:0] rightNext;
  logic                   leftSample;
  logic                   slotEnd;
  logic                   rightSample;
  logic                   complete;

  assign LRSEL = 1'b0;

  always_comb begin
    leftSample  = enable && running && (divCount == DIV_HALF_LAST);
    slotEnd     = enable && running && (divCount == DIV_LAST);
    rightSample = (STEREO != 0) && slotEnd;
    complete    = slotEnd && (bitCount == BIT_LAST);
    leftNext    = {leftShift[WORD_LENGTH-2:0], dataIn};
    rightNext   = {rightShift, dataIn};
    // The first enabled edge only starts the clock: divCount stays at 0 so the
    // cycle after enable is sampled is the first high cycle of slot 0.
    divNext = '0;
    if (running && (divCount != DIV_LAST)) begin
      divNext = divCount + 1'b1;
    end
  end

  // Divider, bit counter and shift registers
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      running    <= 1'b0;
      divCount   <= '0;
      micClock   <= 1'b0;
      bitCount   <= '0;
      leftShift  <= '0;
      rightShift <= '0;
    end else if (!enable) begin
      running    <= 1'b0;
      divCount   <= '0;
      micClock   <= 1'b0;
      bitCount   <= '0;
      leftShift  <= '0;
      rightShift <= '0;
    end else begin
      running  <= 1'b1;
      divCount <= divNext;
      // Registered from the next count so micClock is a clean flop output.
      micClock <= (divNext < DIV_HALF);
      if (leftSample) begin
        leftShift <= leftNext;
      end
      if (rightSample) begin
        rightShift <= rightNext[WORD_LENGTH-2:0];
      end
      if (slotEnd) begin
        bitCount <= (bitCount == BIT_LAST) ? '0 : bitCount + 1'b1;
      end
    end
  end

  // Output words and handshake; keeps working while capture is disabled.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      leftData  <= '0;
      rightData <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete) begin
        leftData <= leftShift;
        if (STEREO != 0) begin
          rightData <= rightNext;
        end
        valid   <= 1'b1;
        // An accept on the completion edge consumes the old word, so no loss.
        overrun <= valid && !ready;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdm_deserializer.sv
// tb/tb_pdm_deserializer.sv - self-checking bench for pdm_deserializer (mono and stereo builds)
module tb_pdm_deserializer;

  localparam int CD   = 4;
  localparam int WL   = 16;
  localparam int HALF = CD / 2;

  logic        clock = 1'b0;
  logic        resetN, enable, dataIn, ready;
  logic        m_mic, m_lr, m_valid, m_ovr;
  logic [15:0] m_left, m_right;
  logic        s_mic, s_lr, s_valid, s_ovr;
  logic [15:0] s_left, s_right;

  int passed = 0;
  int total  = 0;

  // Words the bench believes the DUT currently holds.
  logic [15:0] exp_left, exp_right;

  always #5 clock = ~clock;

  pdm_deserializer #(.WORD_LENGTH(WL), .CLK_DIV(CD), .STEREO(0)) u_mono (
    .clock(clock), .resetN(resetN), .enable(enable), .dataIn(dataIn),
    .micClock(m_mic), .LRSEL(m_lr), .leftData(m_left), .rightData(m_right),
    .valid(m_valid), .ready(ready), .overrun(m_ovr)
  );

  pdm_deserializer #(.WORD_LENGTH(WL), .CLK_DIV(CD), .STEREO(1)) u_stereo (
    .clock(clock), .resetN(resetN), .enable(enable), .dataIn(dataIn),
    .micClock(s_mic), .LRSEL(s_lr), .leftData(s_left), .rightData(s_right),
    .valid(s_valid), .ready(ready), .overrun(s_ovr)
  );

  // Reference stimulus: during the high half of each bit slot the line carries
  // the left bit, during the low half the right bit, MSB first. Must be called
  // at the negedge of slot 0, cycle 0 (cycle k). Returns at the negedge of the
  // cycle after the last driven one. Observes the expected micClock waveform,
  // first cycle valid is seen, valid on the last cycle, and overrun pulses.
  task automatic stream(input logic [15:0] l, input logic [15:0] r, input int nslots,
                        input bit ready_last, output int fv, output logic vlast,
                        output int novr, output int mcerr);
    fv = -1; vlast = 1'b0; novr = 0; mcerr = 0;
    for (int c = 0; c < nslots * CD; c++) begin
      int slot = c / CD;
      int ph   = c % CD;
      dataIn = (ph < HALF) ? l[15-slot] : r[15-slot];
      if ((s_mic !== (ph < HALF)) || (m_mic !== (ph < HALF))) mcerr++;
      if ((s_valid || m_valid) && fv < 0) fv = c;
      if (s_ovr || m_ovr) novr++;
      if (c == nslots * CD - 1) vlast = s_valid;
      if (ready_last && c == nslots * CD - 1) ready = 1'b1;
      @(negedge clock);
    end
  endtask

  task automatic start_capture();
    enable = 1'b1;
    @(negedge clock);
  endtask

  task automatic drop_capture();
    enable = 1'b0;
    @(negedge clock);
  endtask

  task automatic accept();
    ready = 1'b1;
    @(negedge clock);
    ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    total++; if ({s_mic, s_lr, s_valid, s_ovr, s_left, s_right} !== 36'd0) $display("FAIL reset_stereo_outputs: got %h want 0", {s_mic, s_lr, s_valid, s_ovr, s_left, s_right}); else passed++;
    total++; if ({m_mic, m_lr, m_valid, m_ovr, m_left, m_right} !== 36'd0) $display("FAIL reset_mono_outputs: got %h want 0", {m_mic, m_lr, m_valid, m_ovr, m_left, m_right}); else passed++;
    resetN = 1'b1;
    repeat (3) @(negedge clock);
    total++; if (s_mic !== 1'b0 || s_valid !== 1'b0) $display("FAIL idle_disabled: got mic=%b valid=%b want 0/0", s_mic, s_valid); else passed++;
  endtask

  task automatic test_mono();
    logic [15:0] r;
    int fv, novr, mcerr;
    logic vl;
    r = 16'($urandom);
    enable = 1'b1;
    total++; if (s_mic !== 1'b0 || m_mic !== 1'b0) $display("FAIL mic_before_enable: got %b/%b want 0", s_mic, m_mic); else passed++;
    @(negedge clock);
    total++; if (s_mic !== 1'b1 || m_mic !== 1'b1) $display("FAIL mic_first_rise: got %b/%b want 1", s_mic, m_mic); else passed++;
    stream(16'hA5C3, r, 16, 1'b0, fv, vl, novr, mcerr);
    exp_left = 16'hA5C3; exp_right = r;
    total++; if (fv != -1) $display("FAIL mono_early_valid: got valid at cycle %0d want none before 64", fv); else passed++;
    total++; if (m_valid !== 1'b1) $display("FAIL mono_valid_k64: got %b want 1", m_valid); else passed++;
    total++; if (m_left !== 16'hA5C3) $display("FAIL mono_left: got %h want a5c3", m_left); else passed++;
    total++; if (m_right !== 16'h0000) $display("FAIL mono_right: got %h want 0000", m_right); else passed++;
    total++; if (s_left !== 16'hA5C3 || s_right !== r) $display("FAIL stereo_side_word: got %h/%h want a5c3/%h", s_left, s_right, r); else passed++;
    total++; if (mcerr != 0) $display("FAIL mono_micclock_shape: got %0d bad cycles want 0", mcerr); else passed++;
    drop_capture();
    accept();
    total++; if (m_valid !== 1'b0 || s_valid !== 1'b0) $display("FAIL mono_accept: got %b/%b want 0", m_valid, s_valid); else passed++;
  endtask

  task automatic test_stereo();
    int fv, novr, mcerr;
    logic vl;
    logic [15:0] l, r;
    start_capture();
    stream(16'h1234, 16'hFEDC, 16, 1'b0, fv, vl, novr, mcerr);
    total++; if (fv != -1 || s_valid !== 1'b1) $display("FAIL stereo_valid: got first=%0d valid=%b want -1/1", fv, s_valid); else passed++;
    total++; if (s_left !== 16'h1234 || s_right !== 16'hFEDC) $display("FAIL stereo_word1: got %h/%h want 1234/fedc", s_left, s_right); else passed++;
    ready = 1'b1;
    stream(16'h0001, 16'h8000, 16, 1'b0, fv, vl, novr, mcerr);
    total++; if (vl !== 1'b0) $display("FAIL b2b_accepted: got valid=%b before load want 0", vl); else passed++;
    total++; if (s_valid !== 1'b1 || s_left !== 16'h0001 || s_right !== 16'h8000) $display("FAIL b2b_word2: got v=%b %h/%h want 1 0001/8000", s_valid, s_left, s_right); else passed++;
    total++; if (novr != 0 || s_ovr !== 1'b0) $display("FAIL b2b_no_overrun: got %0d pulses want 0", novr); else passed++;
    for (int i = 0; i < 3; i++) begin
      l = 16'($urandom); r = 16'($urandom);
      stream(l, r, 16, 1'b0, fv, vl, novr, mcerr);
      total++; if (s_valid !== 1'b1 || s_left !== l || s_right !== r || m_left !== l) $display("FAIL rand_word%0d: got v=%b %h/%h mono %h want 1 %h/%h", i, s_valid, s_left, s_right, m_left, l, r); else passed++;
      total++; if (mcerr != 0 || novr != 0) $display("FAIL rand_shape%0d: got mc=%0d ovr=%0d want 0/0", i, mcerr, novr); else passed++;
      exp_left = l; exp_right = r;
    end
    ready = 1'b0;
    drop_capture();
  endtask

  task automatic test_overrun();
    int fv, novr, mcerr, total_ovr;
    logic vl;
    logic [15:0] r1, r2;
    r1 = 16'($urandom); r2 = 16'($urandom);
    accept();
    total++; if (s_valid !== 1'b0) $display("FAIL ovr_pre_accept: got %b want 0", s_valid); else passed++;
    start_capture();
    stream(16'h1111, r1, 16, 1'b0, fv, vl, novr, mcerr);
    total_ovr = novr;
    stream(16'h2222, r2, 16, 1'b0, fv, vl, novr, mcerr);
    total_ovr += novr;
    total++; if (total_ovr != 0) $display("FAIL ovr_early_pulse: got %0d pulses want 0", total_ovr); else passed++;
    total++; if (s_ovr !== 1'b1 || m_ovr !== 1'b1) $display("FAIL ovr_pulse: got %b/%b want 1", s_ovr, m_ovr); else passed++;
    total++; if (s_valid !== 1'b1 || s_left !== 16'h2222 || s_right !== r2) $display("FAIL ovr_data: got v=%b %h/%h want 1 2222/%h", s_valid, s_left, s_right, r2); else passed++;
    exp_left = 16'h2222; exp_right = r2;
    drop_capture();
    total++; if (s_ovr !== 1'b0 || m_ovr !== 1'b0 || s_valid !== 1'b1) $display("FAIL ovr_one_cycle: got ovr=%b/%b valid=%b want 0/0/1", s_ovr, m_ovr, s_valid); else passed++;
  endtask

  task automatic test_simultaneous();
    int fv, novr, mcerr;
    logic vl;
    logic [15:0] l, r;
    l = 16'($urandom); r = 16'($urandom);
    start_capture();
    stream(l, r, 16, 1'b1, fv, vl, novr, mcerr);
    ready = 1'b0;
    total++; if (vl !== 1'b1 || novr != 0) $display("FAIL sim_before: got valid=%b pulses=%0d want 1/0", vl, novr); else passed++;
    total++; if (s_valid !== 1'b1 || s_left !== l || s_right !== r) $display("FAIL sim_load: got v=%b %h/%h want 1 %h/%h", s_valid, s_left, s_right, l, r); else passed++;
    total++; if (s_ovr !== 1'b0 || m_ovr !== 1'b0) $display("FAIL sim_no_overrun: got %b/%b want 0", s_ovr, m_ovr); else passed++;
    exp_left = l; exp_right = r;
    @(negedge clock);
    total++; if (s_valid !== 1'b1 || s_ovr !== 1'b0) $display("FAIL sim_hold: got valid=%b ovr=%b want 1/0", s_valid, s_ovr); else passed++;
    drop_capture();
  endtask

  task automatic test_enable_drop();
    int fv, novr, mcerr;
    logic vl;
    logic [15:0] l, r;
    start_capture();
    stream(16'($urandom), 16'($urandom), 7, 1'b0, fv, vl, novr, mcerr);
    drop_capture();
    total++; if (s_mic !== 1'b0 || m_mic !== 1'b0) $display("FAIL drop_mic_low: got %b/%b want 0", s_mic, m_mic); else passed++;
    total++; if (s_valid !== 1'b1 || s_left !== exp_left || s_right !== exp_right) $display("FAIL drop_retain: got v=%b %h/%h want 1 %h/%h", s_valid, s_left, s_right, exp_left, exp_right); else passed++;
    accept();
    total++; if (s_valid !== 1'b0) $display("FAIL drop_accept: got %b want 0", s_valid); else passed++;
    l = 16'($urandom); r = 16'($urandom);
    start_capture();
    stream(l, r, 16, 1'b0, fv, vl, novr, mcerr);
    total++; if (fv != -1 || s_valid !== 1'b1) $display("FAIL drop_restart_timing: got first=%0d valid=%b want -1/1", fv, s_valid); else passed++;
    total++; if (s_left !== l || s_right !== r || mcerr != 0) $display("FAIL drop_restart_word: got %h/%h mc=%0d want %h/%h 0", s_left, s_right, mcerr, l, r); else passed++;
    exp_left = l; exp_right = r;
    drop_capture();
  endtask

  task automatic test_reset_midword();
    int fv, novr, mcerr;
    logic vl;
    logic [15:0] l, r;
    start_capture();
    stream(16'($urandom), 16'($urandom), 5, 1'b0, fv, vl, novr, mcerr);
    total++; if (s_valid !== 1'b1) $display("FAIL rst_mid_pre_valid: got %b want 1", s_valid); else passed++;
    #2 resetN = 1'b0;
    #1;
    total++; if ({s_mic, s_lr, s_valid, s_ovr, s_left, s_right} !== 36'd0) $display("FAIL rst_mid_async_stereo: got %h want 0", {s_mic, s_lr, s_valid, s_ovr, s_left, s_right}); else passed++;
    total++; if ({m_mic, m_lr, m_valid, m_ovr, m_left, m_right} !== 36'd0) $display("FAIL rst_mid_async_mono: got %h want 0", {m_mic, m_lr, m_valid, m_ovr, m_left, m_right}); else passed++;
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    total++; if (s_mic !== 1'b1 || s_valid !== 1'b0) $display("FAIL rst_mid_restart: got mic=%b valid=%b want 1/0", s_mic, s_valid); else passed++;
    l = 16'($urandom); r = 16'($urandom);
    stream(l, r, 16, 1'b0, fv, vl, novr, mcerr);
    total++; if (fv != -1 || s_valid !== 1'b1 || s_left !== l || s_right !== r) $display("FAIL rst_mid_word: got first=%0d v=%b %h/%h want -1 1 %h/%h", fv, s_valid, s_left, s_right, l, r); else passed++;
    drop_capture();
  endtask

  initial begin
    resetN = 1'b0; enable = 1'b0; dataIn = 1'b0; ready = 1'b0;
    exp_left = '0; exp_right = '0;
    test_reset();
    test_mono();
    test_stereo();
    test_overrun();
    test_simultaneous();
    test_enable_drop();
    test_reset_midword();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pdm_deserializer.md
# pdm_deserializer

Parametrised PDM microphone front end: generates the microphone bit clock from the system clock and samples one or two interleaved PDM channels on the shared data line. It assembles each channel into a WORD_LENGTH-bit word and presents the word pair on a valid/ready interface. It sits between the board microphone pins and the decimation/filter chain.

## Interface
- WORD_LENGTH, 16: bits per assembled word (2..32).
- CLK_DIV, 100: system clocks per microphone clock period; must be even and at least 4.
- STEREO, 0: 0 = left channel only; 1 = left and right interleaved on dataIn.
- clock  in  1  system clock; all flops are rising-edge.
- resetN  in  1  asynchronous, active-low reset.
- enable  in  1  run capture; low stops the microphone clock and discards any partial word.
- dataIn  in  1  PDM data from the microphone(s).
- micClock  out  1  microphone bit clock, driven directly from a flop.
- LRSEL  out  1  microphone channel select; constant 0 (left). The right microphone is strapped high on the board.
- leftData  out  WORD_LENGTH  last completed left word.
- rightData  out  WORD_LENGTH  last completed right word; held at 0 when STEREO=0.
- valid  out  1  leftData/rightData hold an unconsumed word.
- ready  in  1  consumer accepts the word.
- overrun  out  1  one-cycle pulse when an unconsumed word is overwritten.

## Operation
- Reset (resetN=0) takes effect immediately. While reset is asserted:
  - micClock=0, LRSEL=0, leftData=0, rightData=0, valid=0, overrun=0.
  - divCount, bitCount and both shift registers are cleared.
- Divider: divCount runs 0..CLK_DIV-1 and wraps while enable=1.
  - micClock=1 while divCount is in 0..CLK_DIV/2-1; otherwise 0.
  - Each micClock period is one bit slot.
- Left sample: taken on the cycle where divCount=CLK_DIV/2-1, the last high cycle.
  - The bit is shifted into leftShift from the LSB, so the first bit received ends at the MSB.
- Right sample (STEREO=1 only): taken on the cycle where divCount=CLK_DIV-1, the last low cycle. The bit is shifted into rightShift the same way.
- bitCount runs 0..WORD_LENGTH-1 and advances at divCount=CLK_DIV-1.
- Word completion: the cycle where bitCount=WORD_LENGTH-1 and divCount=CLK_DIV-1, in both modes.
  - In mono, the completing word's final bit comes from the left sample earlier in that slot.
  - On that clock edge, leftData and rightData load the shift registers (including the bit being sampled), valid is set, and bitCount wraps to 0.
- Handshake:
  - A word transfers on an edge where valid=1 and ready=1; valid clears on that edge.
  - If a completion occurs on the same edge, the new word loads, valid stays 1, and overrun does not pulse.
- Overrun: completion with valid=1 and ready=0 overwrites both data outputs, keeps valid=1, and pulses overrun for one cycle.
- enable=0:
  - divCount, bitCount and the shift registers clear, and micClock=0 on the next edge.
  - leftData, rightData and valid hold, and the handshake keeps working.
- enable 0→1: divCount=0 (micClock rising) on the cycle after enable is first sampled high.

## Timing
- Let cycle k be the first cycle with divCount=0 after enable.
  - The first left sample is at cycle k+CLK_DIV/2-1.
  - The last sample of the first word is at cycle k+WORD_LENGTH*CLK_DIV-1.
  - valid and the new data appear at cycle k+WORD_LENGTH*CLK_DIV.
- Steady state: one word every WORD_LENGTH*CLK_DIV cycles.
- micClock duty cycle is exactly 50%, with no glitches; enable deassertion may truncate the high phase only.
- overrun is high for exactly the one cycle following the overwriting edge.
- Reset released mid-stream: capture restarts cleanly from bitCount=0, with no stale valid.

## Test plan
- Reset: assert resetN=0 mid-word with valid=1. All outputs go to 0 immediately, with no clock edge needed. After release with enable=1, micClock first rises one cycle after enable is sampled.
- Mono capture (CLK_DIV=4, WORD_LENGTH=16, STEREO=0): drive 0xA5C3 MSB-first at the left sample points. Required: leftData=0xA5C3, rightData=0, and valid rising at k+64.
- Stereo (STEREO=1): interleave left 0x1234 with right 0xFEDC. Required: leftData=0x1234, rightData=0xFEDC, valid=1. Then send a second pair 0x0001/0x8000 with ready=1 and check it back-to-back.
- Overrun: hold ready=0 across two words 0x1111 then 0x2222. Required: a single one-cycle overrun pulse at the second load, leftData=0x2222, valid still 1.
- Simultaneous accept and completion: assert ready=1 exactly on the completion edge. Required: valid stays 1, new data is loaded, overrun=0.
- Enable drop: deassert enable after 7 bits, then reassert. Required: micClock goes low, the partial word is discarded, and the next word is assembled only from bits sent after reassertion. Any previously valid word is retained until accepted.
